// File: rtl/mult_operand_issue_tt_pkg.sv
// Shared types for the taint-tracked multiplier operand front-end: FSM states,
// the queued entry layout and the width of the per-entry taint reduction.
package mult_tt_pkg;

  localparam int OP_W        = 4;
  localparam int TAINT_RED_W = 2 * OP_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] multiplier;
    logic [OP_W-1:0] multiplier_t;
    logic [OP_W-1:0] multiplicand;
    logic [OP_W-1:0] multiplicand_t;
    logic            ent_t;
  } entry_t;

  function automatic logic taint_any(input logic [TAINT_RED_W-1:0] v);
    return |v;
  endfunction

endpackage

// File: rtl/mult_operand_issue_tt_fifo.sv
// Operand-pair FIFO with synchronous reset; in-order, power-of-two depth.
// occ_t ORs the entry taint of every occupied slot, so it is valid only for live entries.
module tt_fifo
  import mult_tt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_ent,
  input  logic   pop,
  output entry_t head_ent,
  output logic   empty,
  output logic   full,
  output logic   occ_t
);

  entry_t          mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q;
  logic [PTRW-1:0] rd_ptr_q;
  logic [PTRW:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PTRW+1)'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_ent = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTRW+1)'(1);
        2'b01:   count_q <= count_q - (PTRW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: pointers and count alone define which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_ent;
  end

  always_comb begin
    occ_t = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PTRW+1)'(k) < count_q) occ_t = occ_t | mem_q[rd_ptr_q + PTRW'(k)].ent_t;
    end
  end

endmodule

// File: rtl/mult_operand_issue_tt.sv
// Taint-tracked operand issue stage: queues operand pairs, issues one per start pulse
// and waits for productDone. Build option TAINT_STATE_STICKY_EN keeps state taint until reset.
module mult_operand_issue_tt
  import mult_tt_pkg::*;
#(
  parameter int WIDTH = OP_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_valid_t,
  input  logic [WIDTH-1:0] in_multiplier,
  input  logic [WIDTH-1:0] in_multiplier_t,
  input  logic [WIDTH-1:0] in_multiplicand,
  input  logic [WIDTH-1:0] in_multiplicand_t,
  output logic             in_ready,
  output logic             in_ready_t,
  output logic             start,
  output logic             start_t,
  output logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] multiplier_t,
  output logic [WIDTH-1:0] multiplicand,
  output logic [WIDTH-1:0] multiplicand_t,
  input  logic             productDone,
  input  logic             productDone_t,
  output logic             busy,
  output logic             busy_t
);

  localparam int PTRW = $clog2(DEPTH);

  entry_t           in_ent;
  entry_t           head_ent;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic             occ_t;
  state_e           state_q;
  logic             st_t_q;
  logic             st_issue_d;
  logic             st_done_d;
  logic             start_q;
  logic             start_t_q;
  logic             busy_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] mplier_t_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mcand_t_q;

  always_comb begin
    in_ent.multiplier     = in_multiplier;
    in_ent.multiplier_t   = in_multiplier_t;
    in_ent.multiplicand   = in_multiplicand;
    in_ent.multiplicand_t = in_multiplicand_t;
    in_ent.ent_t          = taint_any({in_valid_t, in_multiplier_t, in_multiplicand_t});
  end

  assign in_ready   = ~rst & ~fifo_full;
  assign in_ready_t = ~rst & occ_t;
  assign push       = in_valid & in_ready;
  // The head leaves the FIFO at the end of the start cycle, so a full FIFO stays full during ISSUE.
  assign pop        = (state_q == ISSUE);

  tt_fifo #(
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_ent (in_ent),
    .pop      (pop),
    .head_ent (head_ent),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .occ_t    (occ_t)
  );

`ifdef TAINT_STATE_STICKY_EN
  assign st_issue_d = st_t_q | head_ent.ent_t;
  assign st_done_d  = st_t_q | productDone_t;
`else
  assign st_issue_d = head_ent.ent_t;
  assign st_done_d  = productDone_t;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      st_t_q     <= 1'b0;
      start_q    <= 1'b0;
      start_t_q  <= 1'b0;
      busy_q     <= 1'b0;
      mplier_q   <= '0;
      mplier_t_q <= '0;
      mcand_q    <= '0;
      mcand_t_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q    <= ISSUE;
            start_q    <= 1'b1;
            start_t_q  <= st_issue_d;
            st_t_q     <= st_issue_d;
            mplier_q   <= head_ent.multiplier;
            mplier_t_q <= head_ent.multiplier_t;
            mcand_q    <= head_ent.multiplicand;
            mcand_t_q  <= head_ent.multiplicand_t;
          end
        end
        ISSUE: begin
          state_q   <= WAIT;
          start_q   <= 1'b0;
          start_t_q <= 1'b0;
          busy_q    <= 1'b1;
        end
        WAIT: begin
          if (productDone) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            st_t_q  <= st_done_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start          = start_q;
  assign start_t        = start_t_q;
  assign busy           = busy_q;
  assign busy_t         = st_t_q;
  assign multiplier     = mplier_q;
  assign multiplier_t   = mplier_t_q;
  assign multiplicand   = mcand_q;
  assign multiplicand_t = mcand_t_q;

endmodule

// File: tb/tb_mult_operand_issue_tt.sv
// Self-checking bench for mult_operand_issue_tt: constant vector table, directed
// corner sequences and random traffic against a queue-based reference model.
module tb_mult_operand_issue_tt;

  localparam int W = 4;
  localparam int D = 4;
`ifdef TAINT_STATE_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_valid_t;
  logic [W-1:0] in_multiplier, in_multiplier_t, in_multiplicand, in_multiplicand_t;
  logic         in_ready, in_ready_t, start, start_t;
  logic [W-1:0] multiplier, multiplier_t, multiplicand, multiplicand_t;
  logic         productDone, productDone_t, busy, busy_t;

  mult_operand_issue_tt #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_valid_t(in_valid_t),
    .in_multiplier(in_multiplier), .in_multiplier_t(in_multiplier_t),
    .in_multiplicand(in_multiplicand), .in_multiplicand_t(in_multiplicand_t),
    .in_ready(in_ready), .in_ready_t(in_ready_t),
    .start(start), .start_t(start_t),
    .multiplier(multiplier), .multiplier_t(multiplier_t),
    .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
    .productDone(productDone), .productDone_t(productDone_t),
    .busy(busy), .busy_t(busy_t)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] m, mt, c, ct; logic vt; } op_t;
  typedef struct {
    logic [W-1:0] m, mt, c, ct;
    logic vt, pdt;
    logic st_off, st_on, bt_off, bt_on;
  } vec_t;

  // Reference model: pairs accepted but not yet issued, in arrival order.
  op_t q[$];
  op_t nil;
  int  total = 0;
  int  bad = 0;
  bit  outstanding, st_m, sticky_any, prev_start;
  int  pend, n_starts;

  function automatic op_t mk(input logic [W-1:0] m, mt, c, ct, input logic vt);
    op_t o;
    o.m = m; o.mt = mt; o.c = c; o.ct = ct; o.vt = vt;
    return o;
  endfunction

  function automatic bit ent(input op_t o);
    return o.vt | (|o.mt) | (|o.ct);
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.m  = W'($urandom);
    o.c  = W'($urandom);
    o.mt = ($urandom_range(0, 5) == 0) ? W'($urandom) : '0;
    o.ct = ($urandom_range(0, 5) == 0) ? W'($urandom) : '0;
    o.vt = ($urandom_range(0, 7) == 0);
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic observe();
    bit any_t;
    bit exp_t;
    chk("in_ready", in_ready, q.size() != D);
    chk("busy", busy, outstanding);
    if (start) begin
      if (q.size() == 0 || outstanding) begin
        total++; bad++;
        $display("FAIL spurious_start: queue=%0d outstanding=%0d (t=%0t)", q.size(), outstanding, $time);
      end else begin
        exp_t = ent(q[0]) | (STICKY & sticky_any);
        chk("issue_latency", pend, 1);
        chk("start_t", start_t, exp_t);
        chk("multiplier", multiplier, q[0].m);
        chk("multiplier_t", multiplier_t, q[0].mt);
        chk("multiplicand", multiplicand, q[0].c);
        chk("multiplicand_t", multiplicand_t, q[0].ct);
        st_m = exp_t;
        sticky_any |= ent(q[0]);
        n_starts++;
      end
      pend = 0;
    end else if (!outstanding && q.size() > 0) begin
      pend++;
      if (pend > 1) begin
        total++; bad++;
        $display("FAIL issue_timeout: no start with %0d queued (t=%0t)", q.size(), $time);
        pend = 0;
      end
    end
    prev_start = start;
    any_t = 1'b0;
    foreach (q[i]) any_t |= ent(q[i]);
    chk("in_ready_t", in_ready_t, any_t);
    chk("busy_t", busy_t, st_m);
  endtask

  // Drive one cycle, advance the model across the clock edge, then check.
  task automatic step(input bit v, input op_t o, input bit pd, input bit pdt);
    bit acc, done;
    in_valid = v; in_valid_t = o.vt;
    in_multiplier = o.m; in_multiplier_t = o.mt;
    in_multiplicand = o.c; in_multiplicand_t = o.ct;
    productDone = pd; productDone_t = pdt;
    acc  = v && (q.size() != D);
    done = outstanding && pd;
    @(posedge clk); #1;
    if (done) begin
      outstanding = 1'b0;
      st_m = STICKY ? (st_m | pdt) : pdt;
      sticky_any |= pdt;
    end
    if (prev_start && q.size() > 0) begin
      void'(q.pop_front());
      outstanding = 1'b1;
    end
    if (acc) q.push_back(o);
    in_valid = 1'b0; in_valid_t = 1'b0; productDone = 1'b0; productDone_t = 1'b0;
    observe();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_valid_t = 1'b0; productDone = 1'b0; productDone_t = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_start", start, 0);
    chk("rst_start_t", start_t, 0);
    chk("rst_busy", busy, 0);
    chk("rst_busy_t", busy_t, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_in_ready_t", in_ready_t, 0);
    chk("rst_mult", multiplier, 0);
    chk("rst_mult_t", multiplier_t, 0);
    chk("rst_mcand", multiplicand, 0);
    chk("rst_mcand_t", multiplicand_t, 0);
    rst = 1'b0; #1;
    chk("rst_release_ready", in_ready, 1);
    q.delete();
    outstanding = 0; st_m = 0; sticky_any = 0; prev_start = 0; pend = 0;
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while ((q.size() > 0 || outstanding || prev_start) && c < maxc) begin
      step(1'b0, nil, outstanding && ($urandom_range(0, 2) == 0), 1'b0);
      c++;
    end
    if (q.size() > 0 || outstanding) begin
      total++; bad++;
      $display("FAIL drain_timeout: queue=%0d outstanding=%0d", q.size(), outstanding);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    op_t  op, fill_ops[4];
    int   n0, s, k, c;
    bit   v, pd;

    nil = mk('0, '0, '0, '0, 1'b0);
    in_multiplier = '0; in_multiplier_t = '0; in_multiplicand = '0; in_multiplicand_t = '0;
    //          m      mt       c      ct       vt  pdt  st_off st_on bt_off bt_on
    tbl[0] = '{4'd3,  4'b0000, 4'd5,  4'b0000, 0,  0,   0,     0,    0,     0};
    tbl[1] = '{4'd6,  4'b0000, 4'd7,  4'b0100, 0,  0,   1,     1,    0,     1};
    tbl[2] = '{4'd2,  4'b0000, 4'd9,  4'b0000, 0,  0,   0,     1,    0,     1};
    tbl[3] = '{4'd15, 4'b0000, 4'd15, 4'b0000, 0,  1,   0,     1,    1,     1};
    tbl[4] = '{4'd1,  4'b0000, 4'd1,  4'b0000, 0,  0,   0,     1,    0,     1};
    tbl[5] = '{4'd4,  4'b0000, 4'd4,  4'b0000, 1,  0,   1,     1,    0,     1};
    tbl[6] = '{4'd8,  4'b1000, 4'd2,  4'b0000, 0,  0,   1,     1,    0,     1};

    do_reset();

    // Single operations from an empty, idle front-end.
    for (int i = 0; i < 7; i++) begin
      op = mk(tbl[i].m, tbl[i].mt, tbl[i].c, tbl[i].ct, tbl[i].vt);
      step(1'b1, op, 1'b0, 1'b0);
      chk("v_lat_early", start, 0);
      step(1'b0, nil, 1'b0, 1'b0);
      chk("v_start", start, 1);
      chk("v_mult", multiplier, tbl[i].m);
      chk("v_mult_t", multiplier_t, tbl[i].mt);
      chk("v_mcand", multiplicand, tbl[i].c);
      chk("v_mcand_t", multiplicand_t, tbl[i].ct);
      chk("v_start_t", start_t, STICKY ? tbl[i].st_on : tbl[i].st_off);
      step(1'b0, nil, 1'b0, 1'b0);
      chk("v_busy", busy, 1);
      chk("v_start_pulse", start, 0);
      step(1'b0, nil, 1'b1, tbl[i].pdt);
      chk("v_busy_done", busy, 0);
      chk("v_busy_t_idle", busy_t, STICKY ? tbl[i].bt_on : tbl[i].bt_off);
    end

    // Fill to full while the multiplier is stalled.
    n0 = n_starts;
    fill_ops[0] = mk(4'd2, 0, 4'd3, 0, 0);
    fill_ops[1] = mk(4'd4, 0, 4'd5, 4'b0001, 0);
    fill_ops[2] = mk(4'd6, 0, 4'd7, 0, 0);
    fill_ops[3] = mk(4'd8, 0, 4'd9, 0, 0);
    step(1'b1, mk(4'd1, 0, 4'd1, 0, 0), 1'b0, 1'b0);
    step(1'b0, nil, 1'b0, 1'b0);
    step(1'b0, nil, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, fill_ops[i], 1'b0, 1'b0);
    chk("full_ready", in_ready, 0);
    step(1'b1, mk(4'd15, 0, 4'd14, 0, 0), 1'b0, 1'b0);
    chk("full_hold", in_ready, 0);
    step(1'b0, nil, 1'b1, 1'b0);
    chk("full_idle_ready", in_ready, 0);
    step(1'b0, nil, 1'b0, 1'b0);
    chk("full_issue_start", start, 1);
    chk("full_issue_mult", multiplier, 4'd2);
    chk("full_issue_ready", in_ready, 0);
    step(1'b0, nil, 1'b0, 1'b0);
    chk("full_ready_rise", in_ready, 1);
    drain(200);
    chk("full_issue_count", n_starts - n0, 5);

    // Reset while WAIT with two entries queued.
    step(1'b1, mk(4'd3, 0, 4'd3, 0, 0), 1'b0, 1'b0);
    step(1'b1, mk(4'd5, 0, 4'd6, 4'b0010, 0), 1'b0, 1'b0);
    step(1'b1, mk(4'd7, 0, 4'd8, 0, 0), 1'b0, 1'b0);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_ready_t", in_ready_t, 1);
    do_reset();
    s = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, nil, 1'b0, 1'b0);
      s += int'(start);
    end
    chk("rst_no_start", s, 0);
    step(1'b1, mk(4'd9, 0, 4'd10, 0, 0), 1'b0, 1'b0);
    step(1'b0, nil, 1'b0, 1'b0);
    chk("rst_new_start", start, 1);
    chk("rst_new_mult", multiplier, 4'd9);
    drain(50);

    // Ten operations through the four-entry FIFO, pointers wrapping.
    n0 = n_starts; k = 0; c = 0;
    while ((k < 10 || q.size() > 0 || outstanding || prev_start) && c < 600) begin
      v  = (k < 10) && ($urandom_range(0, 1) == 1);
      pd = outstanding && ($urandom_range(0, 2) == 0);
      op = rnd_op();
      if (v && q.size() != D) k++;
      step(v, op, pd, ($urandom_range(0, 3) == 0));
      c++;
    end
    chk("wrap_count", n_starts - n0, 10);

    // Random traffic, including stray productDone outside WAIT.
    for (int i = 0; i < 1500; i++) begin
      v  = ($urandom_range(0, 1) == 1);
      pd = outstanding ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      step(v, rnd_op(), pd, ($urandom_range(0, 3) == 0));
    end
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
